// File: rtl/psram_request_arbiter_if.sv
// Controller-side request bus of the PSRAM request arbiter.
// The arbiter drives the strobes, address and write data; the byte-wide
// PSRAM controller answers with mc_busy.
interface psram_request_arbiter_if;
  logic        mc_read_a;
  logic        mc_read_b;
  logic        mc_write;
  logic [23:0] mc_addr;
  logic [7:0]  mc_din;
  logic        mc_busy;

  modport master (
    output mc_read_a,
    output mc_read_b,
    output mc_write,
    output mc_addr,
    output mc_din,
    input  mc_busy
  );

  modport slave (
    input  mc_read_a,
    input  mc_read_b,
    input  mc_write,
    input  mc_addr,
    input  mc_din,
    output mc_busy
  );
endinterface

// File: rtl/psram_request_arbiter.sv
// PSRAM request arbiter: NES core slot requests pass straight through to the
// controller with absolute priority; ROM loader bytes are queued in a FIFO
// and drained only in cycles that can never collide with a NES memory slot.
module psram_request_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 22
) (
  input  logic                          clk,
  input  logic                          CPU_RESET,
  input  logic [1:0]                    nes_phase,
  input  logic                          nes_hold,
  input  logic                          cpu_rd,
  input  logic                          ppu_rd,
  input  logic                          nes_wr,
  input  logic [ADDR_W-1:0]             nes_addr,
  input  logic [7:0]                    nes_wdata,
  input  logic                          ldr_wr,
  input  logic [ADDR_W-1:0]             ldr_addr,
  input  logic [7:0]                    ldr_wdata,
  psram_request_arbiter_if.master       mc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ldr_idle,
  output logic                          ldr_overflow,
  output logic                          nes_miss
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // WAIT_GAP is the cycle right after an issue, where mc_busy may not be
  // visible yet; WAIT covers the rest of the controller transaction.
  typedef enum logic [1:0] {IDLE, WAIT_GAP, WAIT} state_t;

  state_t              state, state_n;
  logic [ADDR_W+7:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                last_ldr;
  logic [23:0]         addr_q;
  logic [7:0]          din_q;

  logic                blocked, nes_slot, nes_req, nes_go, ldr_go, nes_multi;
  logic                fifo_empty, fifo_full, push_ok, nes_lost, waiting;
  logic [ADDR_W+7:0]   head;
  logic                rd_a, rd_b, wr;
  logic [23:0]         sel_addr;
  logic [7:0]          sel_din;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign blocked    = (state == WAIT_GAP) || mc.mc_busy || CPU_RESET;
  assign nes_slot   = (nes_phase == 2'd0) && !nes_hold;
  assign nes_req    = cpu_rd || ppu_rd || nes_wr;
  assign nes_multi  = (cpu_rd && (nes_wr || ppu_rd)) || (nes_wr && ppu_rd);
  assign nes_go     = nes_slot && nes_req && !blocked;
  assign ldr_go     = !fifo_empty && !blocked &&
                      (nes_hold || ((nes_phase == 2'd0) && !nes_req));
  assign push_ok    = ldr_wr && (!fifo_full || ldr_go);
  assign nes_lost   = nes_slot && ((nes_req && blocked) || (nes_go && nes_multi));
  assign waiting    = (state == WAIT_GAP) || ((state == WAIT) && mc.mc_busy);

  assign mc.mc_read_a = rd_a;
  assign mc.mc_read_b = rd_b;
  assign mc.mc_write  = wr;
  assign mc.mc_addr   = sel_addr;
  assign mc.mc_din    = sel_din;
  assign fifo_level   = level;
  assign ldr_idle     = fifo_empty && !(waiting && last_ldr);

  // Select this cycle's request (NES first, then FIFO head) and hold the
  // last driven address/data when nothing is issued.
  always_comb begin
    rd_a     = 1'b0;
    rd_b     = 1'b0;
    wr       = 1'b0;
    sel_addr = addr_q;
    sel_din  = din_q;
    if (nes_go) begin
      sel_addr = 24'(nes_addr);
      if (cpu_rd) begin
        rd_a = 1'b1;
      end else if (nes_wr) begin
        wr      = 1'b1;
        sel_din = nes_wdata;
      end else begin
        rd_b = 1'b1;
      end
    end else if (ldr_go) begin
      wr       = 1'b1;
      sel_addr = 24'(head[ADDR_W+7:8]);
      sel_din  = head[7:0];
    end
  end

  // Next-state logic: any issue restarts the wait, which ends once the
  // controller has dropped busy after the masked first cycle.
  always_comb begin
    state_n = state;
    if (nes_go || ldr_go) begin
      state_n = WAIT_GAP;
    end else begin
      case (state)
        WAIT_GAP: state_n = WAIT;
        WAIT:     if (!mc.mc_busy) state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // State, held bus values, FIFO pointers/level and sticky flags.
  always_ff @(posedge clk or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state        <= IDLE;
      last_ldr     <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      ldr_overflow <= 1'b0;
      nes_miss     <= 1'b0;
    end else begin
      state <= state_n;
      if (nes_go || ldr_go) begin
        last_ldr <= ldr_go && !nes_go;
        addr_q   <= sel_addr;
      end
      if (wr) din_q <= sel_din;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ldr_go)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, ldr_go})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (ldr_wr && fifo_full && !ldr_go) ldr_overflow <= 1'b1;
      if (nes_lost) nes_miss <= 1'b1;
    end
  end

  // FIFO storage has no reset; only the pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {ldr_addr, ldr_wdata};
  end

endmodule

// File: tb/tb_psram_request_arbiter.sv
// Directed testbench for psram_request_arbiter with a behavioural PSRAM
// controller (busy for 3 cycles after each accepted strobe).
module tb_psram_request_arbiter;

  logic        clk = 1'b0;
  logic        CPU_RESET;
  logic [1:0]  nes_phase;
  logic        nes_hold, cpu_rd, ppu_rd, nes_wr;
  logic [21:0] nes_addr;
  logic [7:0]  nes_wdata;
  logic        ldr_wr;
  logic [21:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic [3:0]  fifo_level;
  logic        ldr_idle, ldr_overflow, nes_miss;
  logic        force_busy;
  logic        chk_ra;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int viol = 0;
  int multi = 0;
  int ra_cnt = 0;
  int ra_bad = 0;

  logic [31:0] wr_log [$];
  int          wr_cyc [$];
  logic [1:0]  wr_ph  [$];

  psram_request_arbiter_if mc_bus ();

  psram_request_arbiter #(.FIFO_DEPTH(8), .ADDR_W(22)) dut (
    .clk          (clk),
    .CPU_RESET    (CPU_RESET),
    .nes_phase    (nes_phase),
    .nes_hold     (nes_hold),
    .cpu_rd       (cpu_rd),
    .ppu_rd       (ppu_rd),
    .nes_wr       (nes_wr),
    .nes_addr     (nes_addr),
    .nes_wdata    (nes_wdata),
    .ldr_wr       (ldr_wr),
    .ldr_addr     (ldr_addr),
    .ldr_wdata    (ldr_wdata),
    .mc           (mc_bus.master),
    .fifo_level   (fifo_level),
    .ldr_idle     (ldr_idle),
    .ldr_overflow (ldr_overflow),
    .nes_miss     (nes_miss)
  );

  logic strobe_any;
  assign strobe_any     = mc_bus.mc_read_a || mc_bus.mc_read_b || mc_bus.mc_write;
  assign mc_bus.mc_busy = (busy_cnt != 0) || force_busy;

  always #5 clk = ~clk;

  // Controller model: accepts a strobe only while idle; it is never reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (strobe_any && mc_bus.mc_busy) viol <= viol + 1;
    if (!mc_bus.mc_busy && strobe_any) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Bus monitor: logs every write and counts CPU reads mid-cycle.
  always @(negedge clk) begin
    if ($countones({mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}) > 1)
      multi <= multi + 1;
    if (mc_bus.mc_write) begin
      wr_log.push_back({mc_bus.mc_addr, mc_bus.mc_din});
      wr_cyc.push_back(cyc);
      wr_ph.push_back(nes_phase);
    end
    if (mc_bus.mc_read_a) begin
      ra_cnt <= ra_cnt + 1;
      if (chk_ra && mc_bus.mc_addr != 24'h00ABCD) ra_bad <= ra_bad + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic c_rd, input logic p_rd, input logic n_wr,
                               input logic l_wr, input logic [21:0] l_addr,
                               input logic [7:0] l_data);
    cpu_rd    = c_rd;
    ppu_rd    = p_rd;
    nes_wr    = n_wr;
    ldr_wr    = l_wr;
    ldr_addr  = l_addr;
    ldr_wdata = l_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    nes_phase = nes_phase + 2'd1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    repeat (n) step();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    CPU_RESET = 1'b1;
    step();
    step();
    CPU_RESET = 1'b0;
    step();
  endtask

  task automatic clearLog();
    wr_log.delete();
    wr_cyc.delete();
    wr_ph.delete();
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [21:0] a, input logic [7:0] d);
    logic [31:0] got;
    got = (idx < wr_log.size()) ? wr_log[idx] : 32'hFFFF_FFFF;
    checkOutput($sformatf("%s[%0d]", tag, idx), got, {2'b00, a, d});
  endtask

  function automatic int minGap();
    int g = 1000;
    for (int i = 1; i < wr_cyc.size(); i++)
      if (wr_cyc[i] - wr_cyc[i-1] < g) g = wr_cyc[i] - wr_cyc[i-1];
    return g;
  endfunction

  initial begin
    int peak;
    int ra0;
    logic all_ph0;
    int keep [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 17};

    CPU_RESET  = 1'b1;
    nes_phase  = 2'd0;
    nes_hold   = 1'b1;
    nes_addr   = 22'h0;
    nes_wdata  = 8'h0;
    force_busy = 1'b0;
    chk_ra     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    step();
    step();
    checkOutput("rst_level",    fifo_level, 0);
    checkOutput("rst_ldr_idle", ldr_idle, 1);
    checkOutput("rst_ovf",      ldr_overflow, 0);
    checkOutput("rst_miss",     nes_miss, 0);
    checkOutput("rst_strobes",  {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 0);
    checkOutput("rst_addr",     mc_bus.mc_addr, 0);
    checkOutput("rst_din",      mc_bus.mc_din, 0);
    CPU_RESET = 1'b0;
    step();

    // Burst of 20 loader bytes with NES held: FIFO saturates, bytes dropped.
    $display("[TB] loader burst with overflow");
    doReset();
    nes_hold = 1'b1;
    idle(2);
    clearLog();
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'(i), 8'(i));
      step();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    idle(40);
    checkOutput("t1_peak",  peak, 8);
    checkOutput("t1_ovf",   ldr_overflow, 1);
    checkOutput("t1_count", wr_log.size(), 13);
    for (int i = 0; i < 13; i++) checkLog("t1_entry", i, 22'(keep[i]), 8'(keep[i]));
    checkOutput("t1_gap",   (minGap() >= 4), 1);
    checkOutput("t1_level", fifo_level, 0);
    checkOutput("t1_idle",  ldr_idle, 1);

    // One loader byte every 6 cycles: nothing lost, order and spacing kept.
    $display("[TB] paced loader writes");
    doReset();
    nes_hold = 1'b1;
    idle(2);
    clearLog();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'(i), 8'(i));
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
      if (i == 0) begin
        step();
        checkOutput("t1b_idle_in_flight", ldr_idle, 0);
        repeat (4) step();
      end else begin
        repeat (5) step();
      end
    end
    idle(10);
    checkOutput("t1b_ovf",   ldr_overflow, 0);
    checkOutput("t1b_count", wr_log.size(), 20);
    for (int i = 0; i < 20; i++) checkLog("t1b_entry", i, 22'(i), 8'(i));
    checkOutput("t1b_gap",   (minGap() >= 4), 1);
    checkOutput("t1b_idle",  ldr_idle, 1);

    // NES CPU reads every slot while the loader queues bytes behind them.
    $display("[TB] NES reads with loader traffic");
    doReset();
    nes_hold = 1'b0;
    nes_addr = 22'h00ABCD;
    clearLog();
    ra0 = ra_cnt;
    chk_ra = 1'b1;
    nes_phase = 2'd0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (k % 5 == 0), 22'(12'h100 + k), 8'(k));
      step();
    end
    chk_ra = 1'b0;
    checkOutput("t2_reads",    ra_cnt - ra0, 10);
    checkOutput("t2_read_adr", ra_bad, 0);
    checkOutput("t2_no_ldr",   wr_log.size(), 0);
    checkOutput("t2_level",    fifo_level, 8);
    checkOutput("t2_ovf",      ldr_overflow, 0);
    idle(40);
    all_ph0 = 1'b1;
    foreach (wr_ph[i]) if (wr_ph[i] != 2'd0) all_ph0 = 1'b0;
    checkOutput("t2_drain_cnt", wr_log.size(), 8);
    checkOutput("t2_phase0",    all_ph0, 1);
    for (int j = 0; j < 8; j++) checkLog("t2_entry", j, 22'(12'h100 + 5*j), 8'(5*j));
    checkOutput("t2_miss",      nes_miss, 0);

    // Simultaneous CPU and PPU reads: CPU wins, loss is flagged.
    $display("[TB] NES priority and pass-through");
    doReset();
    nes_hold  = 1'b0;
    nes_phase = 2'd0;
    nes_addr  = 22'h3FFFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0);
    #1;
    checkOutput("t3_strobes", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 3'b100);
    checkOutput("t3_addr",    mc_bus.mc_addr, 24'h3FFFFF);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    checkOutput("t3_miss", nes_miss, 1);
    idle(3);
    nes_addr  = 22'h000123;
    nes_wdata = 8'h5A;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h0);
    #1;
    checkOutput("t3_wr_strobes", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 3'b001);
    checkOutput("t3_wr_addr",    mc_bus.mc_addr, 24'h000123);
    checkOutput("t3_wr_din",     mc_bus.mc_din, 8'h5A);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    nes_addr  = 22'h2AAAAA;
    nes_wdata = 8'h00;
    #1;
    checkOutput("t3_hold_strobes", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 0);
    checkOutput("t3_hold_addr",    mc_bus.mc_addr, 24'h000123);
    checkOutput("t3_hold_din",     mc_bus.mc_din, 8'h5A);
    idle(3);
    nes_addr = 22'h000077;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0);
    #1;
    checkOutput("t3_ppu_strobes", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 3'b010);
    checkOutput("t3_ppu_addr",    mc_bus.mc_addr, 24'h000077);
    checkOutput("t3_ppu_din",     mc_bus.mc_din, 8'h5A);
    step();
    idle(4);

    // Controller busy through a NES slot: write dropped, loss flagged.
    $display("[TB] NES request while controller busy");
    doReset();
    nes_hold   = 1'b0;
    force_busy = 1'b1;
    nes_phase  = 2'd0;
    nes_addr   = 22'h000200;
    nes_wdata  = 8'h33;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 8'h0);
    #1;
    checkOutput("t4_no_strobe", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 0);
    step();
    checkOutput("t4_miss", nes_miss, 1);
    force_busy = 1'b0;
    idle(4);

    // Full FIFO with push and pop together, crossing the pointer wrap.
    $display("[TB] full FIFO push/pop");
    doReset();
    nes_hold  = 1'b0;
    nes_addr  = 22'h000040;
    clearLog();
    nes_phase = 2'd0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 22'(12'h200 + k), 8'(8'hA0 + k));
      step();
    end
    checkOutput("t5_full", fifo_level, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'h208, 8'hA8);
    #1;
    checkOutput("t5_pop_head", {mc_bus.mc_write, mc_bus.mc_addr, mc_bus.mc_din}, {1'b1, 24'h000200, 8'hA0});
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    checkOutput("t5_level", fifo_level, 8);
    checkOutput("t5_ovf",   ldr_overflow, 0);
    idle(44);
    checkOutput("t5_count", wr_log.size(), 9);
    for (int i = 0; i < 9; i++) checkLog("t5_entry", i, 22'(12'h200 + i), 8'(8'hA0 + i));

    // Reset while a loader write is in progress at the controller.
    $display("[TB] reset mid-transaction");
    doReset();
    nes_hold = 1'b1;
    idle(6);
    clearLog();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'h000010, 8'hB0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'h000011, 8'hB1);
    #1;
    checkOutput("t6_issue", {mc_bus.mc_write, mc_bus.mc_addr}, {1'b1, 24'h000010});
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    CPU_RESET = 1'b1;
    #1;
    checkOutput("t6_rst_level",   fifo_level, 0);
    checkOutput("t6_rst_idle",    ldr_idle, 1);
    checkOutput("t6_rst_strobes", {mc_bus.mc_read_a, mc_bus.mc_read_b, mc_bus.mc_write}, 0);
    checkOutput("t6_rst_addr",    mc_bus.mc_addr, 0);
    checkOutput("t6_rst_din",     mc_bus.mc_din, 0);
    step();
    CPU_RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 22'h3FFFFF, 8'hC3);
    #1;
    checkOutput("t6_no_issue_a", mc_bus.mc_write, 0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
    #1;
    checkOutput("t6_no_issue_b", mc_bus.mc_write, 0);
    step();
    #1;
    checkOutput("t6_new_write", {mc_bus.mc_write, mc_bus.mc_addr, mc_bus.mc_din}, {1'b1, 24'h3FFFFF, 8'hC3});
    step();
    idle(8);
    checkOutput("t6_count", wr_log.size(), 2);
    checkLog("t6_entry", 1, 22'h3FFFFF, 8'hC3);
    checkOutput("t6_level", fifo_level, 0);

    checkOutput("protocol_viol", viol, 0);
    checkOutput("multi_strobe",  multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
